sti_load_sched: RTL and testbench

- Round-robin scheduler that shares one parallel-to-serial STI serializer among NREQ word sources.
- Picks one pending word, drives the serializer's load/pi_* interface, and holds it stable.
- Counts the serializer's so_valid bit-stream to confirm completion and flags protocol errors.
- Asserts pi_end once every source has delivered its last word, which starts the downstream DAC pad/finish sequence.

---
 rtl/sti_load_sched.sv | 123 ++++++++++++
 tb/tb_sti_load_sched.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sti_load_sched.sv
// sti_load_sched: round-robin loader that shares one STI serializer among NREQ word sources.
// Define STI_SCHED_TIMEOUT_EN to abandon a WAIT that sees no so_valid within TIMEOUT cycles.
module sti_load_sched #(
  parameter int NREQ = 4,
  parameter int IDW = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_data,
  input  logic [5*NREQ-1:0]    req_cfg,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 so_valid,
  output logic                 load,
  output logic [15:0]          pi_data,
  output logic [1:0]           pi_length,
  output logic                 pi_msb,
  output logic                 pi_low,
  output logic                 pi_fill,
  output logic                 pi_end,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 err
);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_SHIFT, S_END} state_t;
  state_t state;
  logic [IDW-1:0] ptr, win;
  logic [NREQ-1:0] done, elig;
  logic found;
  logic [5:0] cnt, exp_bits;
`ifdef STI_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
`endif
  if (NREQ < 2 || NREQ > 8 || IDW < $clog2(NREQ) || TIMEOUT < 1) begin : g_bad_param
    $error("sti_load_sched: illegal parameters");
  end
  assign elig = req_valid & ~done;
  assign exp_bits = {3'(pi_length) + 3'd1, 3'b000};
  // lowest eligible index overall, overridden by the lowest one above ptr
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (elig[i]) begin
        win = IDW'(i);
        found = 1'b1;
      end
    for (int i = NREQ - 1; i >= 0; i--)
      if (elig[i] && i > int'(ptr)) win = IDW'(i);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      ptr <= IDW'(NREQ - 1);
      done <= '0;
      cnt <= '0;
      load <= 1'b0;
      req_ready <= '0;
      pi_data <= '0;
      {pi_length, pi_msb, pi_low, pi_fill} <= '0;
      pi_end <= 1'b0;
      busy <= 1'b0;
      grant_id <= '0;
      err <= 1'b0;
`ifdef STI_SCHED_TIMEOUT_EN
      tcnt <= '0;
`endif
    end else begin
      load <= 1'b0;
      req_ready <= '0;
      case (state)
        S_IDLE:
          if (&done) begin
            pi_end <= 1'b1;
            state <= S_END;
          end else if (found) begin
            pi_data <= req_data[16*int'(win) +: 16];
            {pi_length, pi_msb, pi_low, pi_fill} <= req_cfg[5*int'(win) +: 5];
            grant_id <= win;
            ptr <= win;
            load <= 1'b1;
            req_ready <= NREQ'(1) << win;
            busy <= 1'b1;
            state <= S_ISSUE;
          end
        S_ISSUE: begin
          done <= done | (req_ready & req_last);
          cnt <= '0;
`ifdef STI_SCHED_TIMEOUT_EN
          tcnt <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT:
          if (so_valid) begin
            cnt <= 6'd1;
            state <= S_SHIFT;
          end
`ifdef STI_SCHED_TIMEOUT_EN
          else if (tcnt == TW'(TIMEOUT - 1)) begin
            err <= 1'b1;
            busy <= 1'b0;
            pi_end <= &done;
            state <= S_IDLE;
          end else tcnt <= tcnt + 1'b1;
`endif
        S_SHIFT:
          if (so_valid) begin
            if (cnt == exp_bits) err <= 1'b1;
            else cnt <= cnt + 6'd1;
          end else begin
            if (cnt != exp_bits) err <= 1'b1;
            busy <= 1'b0;
            pi_end <= &done;
            state <= S_IDLE;
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_sti_load_sched.sv
// tb_sti_load_sched: directed table, reset/timeout sequences and random traffic against a round-robin reference model.
module tb_sti_load_sched;
  localparam int NREQ = 4, IDW = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req_valid, req_last, req_ready;
  logic [16*NREQ-1:0] req_data;
  logic [5*NREQ-1:0] req_cfg;
  logic so_valid, load, pi_msb, pi_low, pi_fill, pi_end, busy, err;
  logic [15:0] pi_data;
  logic [1:0] pi_length;
  logic [IDW-1:0] grant_id;
  logic [15:0] s_data [NREQ];
  logic [4:0] s_cfg [NREQ];
  int s_left [NREQ], s_delay [NREQ];
  int n_cmp = 0, n_bad = 0;
  int m_ptr;
  logic [NREQ-1:0] m_done;
  bit m_err;
  always #5 clk = ~clk;
  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_data[16*g +: 16] = s_data[g];
    assign req_cfg[5*g +: 5] = s_cfg[g];
  end
  sti_load_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_cfg(req_cfg),
    .req_last(req_last), .req_ready(req_ready), .so_valid(so_valid), .load(load),
    .pi_data(pi_data), .pi_length(pi_length), .pi_msb(pi_msb), .pi_low(pi_low),
    .pi_fill(pi_fill), .pi_end(pi_end), .busy(busy), .grant_id(grant_id), .err(err)
  );
  typedef struct {
    int g;
    logic [15:0] data;
    logic [4:0] cfg;
    bit last;
    int nbits;
    int exp_err;
    int exp_end;
  } row_t;
  row_t rows [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic set_src(input int i, input logic [15:0] d, input logic [4:0] c, input bit l, input bit v);
    s_data[i] = d;
    s_cfg[i] = c;
    req_last[i] = l;
    req_valid[i] = v;
    s_delay[i] = 0;
  endtask

  task automatic new_word(input int i);
    s_data[i] = 16'($urandom);
    s_cfg[i] = 5'($urandom);
    req_last[i] = (s_left[i] == 1);
  endtask

  task automatic src_consume(input int g);
    s_left[g]--;
    if (s_left[g] > 0) begin
      new_word(g);
      s_delay[g] = $urandom_range(0, 3);
      req_valid[g] = (s_delay[g] == 0);
    end else begin
      s_data[g] = 16'hDEAD;
      req_valid[g] = 1'($urandom_range(0, 1));
      s_delay[g] = 0;
    end
  endtask

  task automatic src_tick();
    for (int i = 0; i < NREQ; i++)
      if (s_delay[i] > 0) begin
        s_delay[i]--;
        if (s_delay[i] == 0) req_valid[i] = 1'b1;
      end
  endtask

  function automatic int m_pick();
    for (int k = 1; k <= NREQ; k++)
      if (req_valid[(m_ptr + k) % NREQ] && !m_done[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    so_valid = 1'b0;
    req_valid = '0;
    req_last = '0;
    for (int i = 0; i < NREQ; i++) begin
      s_data[i] = '0;
      s_cfg[i] = '0;
      s_left[i] = 0;
      s_delay[i] = 0;
    end
    repeat (2) @(negedge clk);
    chk("reset_outputs", {load, req_ready, pi_data, pi_length, pi_msb, pi_low, pi_fill, pi_end, busy, grant_id, err}, 0);
    rst = 1'b0;
    m_ptr = NREQ - 1;
    m_done = '0;
    m_err = 1'b0;
  endtask

  // g_in/err_in/fin_in < 0 take the expectation from the reference model; nbits < 0 sends the correct count
  task automatic xfer(input int g_in, input int nbits, input int gap, input int err_in, input int fin_in, output int waited);
    int g, nb;
    logic [15:0] d;
    logic [4:0] c;
    bit got, held;
    got = 0;
    waited = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      waited++;
      if (load === 1'b1) got = 1;
      else src_tick();
    end
    chk("load_seen", 32'(got), 1);
    if (!got) return;
    g = (g_in >= 0) ? g_in : m_pick();
    chk("eligible_at_load", 32'(g >= 0), 1);
    if (g < 0) return;
    d = s_data[g];
    c = s_cfg[g];
    nb = (nbits < 0) ? 8 * (int'(c[4:3]) + 1) : nbits;
    chk("grant_id", 32'(grant_id), g);
    chk("req_ready", 32'(req_ready), 1 << g);
    chk("pi_data", 32'(pi_data), 32'(d));
    chk("pi_mode", 32'({pi_length, pi_msb, pi_low, pi_fill}), 32'(c));
    m_ptr = g;
    if (req_last[g]) m_done[g] = 1'b1;
    if (nb != 8 * (int'(c[4:3]) + 1)) m_err = 1'b1;
    held = 1;
    @(negedge clk);
    src_consume(g);
    for (int i = 0; i < gap + nb; i++) begin
      if (i > 0) @(negedge clk);
      held &= (pi_data === d) && ({pi_length, pi_msb, pi_low, pi_fill} === c) && (load === 1'b0) && (busy === 1'b1) && (req_ready === '0);
      so_valid = (i >= gap);
    end
    @(negedge clk);
    held &= (pi_data === d) && ({pi_length, pi_msb, pi_low, pi_fill} === c) && (load === 1'b0) && (busy === 1'b1);
    so_valid = 1'b0;
    chk("held_during_xfer", 32'(held), 1);
    @(negedge clk);
    chk("err", 32'(err), (err_in >= 0) ? err_in : int'(m_err));
    chk("busy_idle", 32'(busy), 0);
    chk("pi_end", 32'(pi_end), (fin_in >= 0) ? fin_in : int'(m_done == '1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, loads, iters;
    bit got, quiet;
    rows[0] = '{0, 16'h1111, 5'b00100, 0, 8, 0, 0};
    rows[1] = '{1, 16'h2222, 5'b01010, 0, 16, 0, 0};
    rows[2] = '{2, 16'h3333, 5'b10001, 0, 24, 0, 0};
    rows[3] = '{3, 16'h4444, 5'b11111, 0, 32, 0, 0};
    rows[4] = '{0, 16'h5555, 5'b00000, 1, 8, 0, 0};
    rows[5] = '{1, 16'h6666, 5'b11000, 1, 20, 1, 0};
    rows[6] = '{2, 16'h7777, 5'b01100, 1, 16, 1, 0};
    rows[7] = '{3, 16'h8888, 5'b10010, 1, 24, 1, 1};

    // single source, single last word
    do_reset();
    set_src(0, 16'hA5C3, 5'b00100, 1, 1);
    xfer(0, 8, 1, 0, 0, w);
    loads = 0;
    repeat (20) begin
      @(negedge clk);
      if (load === 1'b1 || req_ready !== '0) loads++;
    end
    chk("single_no_reload", loads, 0);
    chk("single_pi_end_low", 32'(pi_end), 0);

    // all four continuously valid, two words each
    do_reset();
    for (int i = 0; i < NREQ; i++) set_src(i, rows[i].data, rows[i].cfg, rows[i].last, 1);
    for (int k = 0; k < 8; k++) begin
      xfer(rows[k].g, rows[k].nbits, 0, rows[k].exp_err, rows[k].exp_end, w);
      chk("load_spacing", w, 1);
      if (k < 4) set_src(rows[k].g, rows[k+4].data, rows[k+4].cfg, rows[k+4].last, 1);
      else set_src(rows[k].g, 16'hDEAD, 5'b00000, 0, 1);
    end
    quiet = 1;
    repeat (30) begin
      @(negedge clk);
      quiet &= (load === 1'b0) && (req_ready === '0) && (pi_end === 1'b1);
    end
    chk("end_state_quiet", 32'(quiet), 1);

    // asynchronous reset in the middle of a burst
    do_reset();
    for (int i = 0; i < NREQ; i++) set_src(i, 16'h1000 + 16'(i), 5'b00100, 0, 1);
    xfer(0, 8, 0, 0, 0, w);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = (load === 1'b1);
    end
    chk("pre_reset_load", 32'(got), 1);
    chk("pre_reset_grant", 32'(grant_id), 1);
    @(negedge clk);
    so_valid = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("async_reset_outs", {load, busy, req_ready, pi_data, pi_length, pi_msb, pi_low, pi_fill, grant_id}, 0);
    so_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = NREQ - 1;
    m_done = '0;
    m_err = 1'b0;
    for (int i = 0; i < NREQ; i++) set_src(i, 16'h2000 + 16'(i), 5'b01000, 0, 1);
    xfer(0, 16, 0, 0, 0, w);

`ifdef STI_SCHED_TIMEOUT_EN
    do_reset();
    set_src(2, 16'hBEEF, 5'b00000, 1, 1);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = (load === 1'b1);
    end
    chk("timeout_load", 32'(got), 1);
    @(negedge clk);
    req_valid = '0;
    repeat (15) @(negedge clk);
    chk("timeout_still_waiting", {busy, err}, 2'b10);
    @(negedge clk);
    chk("timeout_fired", {busy, err}, 2'b01);
`endif

    // random traffic against the reference model
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      s_left[i] = $urandom_range(1, 4);
      new_word(i);
      s_delay[i] = $urandom_range(0, 3);
      req_valid[i] = (s_delay[i] == 0);
    end
    iters = 0;
    while (m_done != '1 && iters < 60) begin
      xfer(-1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : -1, $urandom_range(0, 3), -1, -1, w);
      iters++;
    end
    chk("random_pi_end", 32'(pi_end), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
